// File: rtl/edge_detect_multi.sv
// Multi-channel async-input edge detector: per-channel synchroniser, glitch filter,
// rise/fall/any-edge pulses and saturating edge counter.

module edge_detect_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_W       = 8,
  parameter bit RESET_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_i,
  input  logic             en_i,
  input  logic             cnt_clr_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             edge_o,
  output logic [CNT_W-1:0] cnt_o
);
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FMAX = FCW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   level_q, level_d, prev_q;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Filter counter drops to 0 whenever the sample agrees with level or en is low,
  // so any return to the current level restarts qualification.
  always_comb begin
    level_d = level_q;
    fcnt_d  = '0;
    if (en_i && (s != level_q)) begin
      if (fcnt_q == FMAX) level_d = s;
      else                fcnt_d  = fcnt_q + 1'b1;
    end
  end

  assign rise_o  = level_q & ~prev_q;
  assign fall_o  = ~level_q & prev_q;
  assign edge_o  = level_q ^ prev_q;
  assign level_o = level_q;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)              cnt_d = '0;
    else if (edge_o && ~&cnt_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q  <= {SYNC_STAGES{RESET_BIT}};
      level_q <= RESET_BIT;
      prev_q  <= RESET_BIT;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      level_q <= level_d;
      prev_q  <= level_q;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module edge_detect_multi #(
  parameter int                NUM_CH      = 2,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILTER_LEN  = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL   = {NUM_CH{1'b1}},
  parameter int                CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_CH-1:0]       d_in,
  input  logic                    en,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       level,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH-1:0]       fall,
  output logic [NUM_CH-1:0]       d_edge,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_detect_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .CNT_W      (CNT_W),
      .RESET_BIT  (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .n_rst    (n_rst),
      .d_i      (d_in[i]),
      .en_i     (en),
      .cnt_clr_i(cnt_clr),
      .level_o  (level[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .edge_o   (d_edge[i]),
      .cnt_o    (edge_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: default instance plus a SYNC_STAGES=3/FILTER_LEN=1/CNT_W=3
// instance, both checked every cycle against a run-length reference model.
module tb_edge_detect_multi;
  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] d_in;
  logic       en, cnt_clr;

  logic [1:0]  lvl0, rise0, fall0, edg0;
  logic [15:0] cnt0;
  logic [1:0]  lvl1, rise1, fall1, edg1;
  logic [5:0]  cnt1;

  always #5 clk = ~clk;

  edge_detect_multi u_dut0 (
    .clk(clk), .n_rst(n_rst), .d_in(d_in), .en(en), .cnt_clr(cnt_clr),
    .level(lvl0), .rise(rise0), .fall(fall0), .d_edge(edg0), .edge_cnt(cnt0)
  );

  edge_detect_multi #(.NUM_CH(2), .SYNC_STAGES(3), .FILTER_LEN(1), .RESET_VAL(2'b11), .CNT_W(3)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .d_in(d_in), .en(en), .cnt_clr(cnt_clr),
    .level(lvl1), .rise(rise1), .fall(fall1), .d_edge(edg1), .edge_cnt(cnt1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: level flips once the input seen SYNC_STAGES cycles earlier has
  // disagreed with it for FILTER_LEN consecutive enabled cycles.
  int         SS[2]   = '{2, 3};
  int         FL[2]   = '{2, 1};
  int         CMAX[2] = '{255, 7};
  bit [1:0]   dlog[$];
  bit [1:0]   m_lvl[2], m_prev[2];
  int         m_run[2][2];
  int         m_cnt[2][2];

  task automatic model_reset();
    dlog.delete();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 2'b11; m_prev[k] = 2'b11;
      for (int c = 0; c < 2; c++) begin m_run[k][c] = 0; m_cnt[k][c] = 0; end
    end
  endtask

  task automatic model_step();
    bit [1:0] s, pulses;
    if (!n_rst) begin model_reset(); return; end
    for (int k = 0; k < 2; k++) begin
      s = (dlog.size() >= SS[k]) ? dlog[dlog.size() - SS[k]] : 2'b11;
      pulses = m_lvl[k] ^ m_prev[k];
      m_prev[k] = m_lvl[k];
      for (int c = 0; c < 2; c++) begin
        if (cnt_clr) m_cnt[k][c] = 0;
        else if (pulses[c] && m_cnt[k][c] < CMAX[k]) m_cnt[k][c]++;
        if (!en || s[c] == m_lvl[k][c]) m_run[k][c] = 0;
        else begin
          m_run[k][c]++;
          if (m_run[k][c] >= FL[k]) begin m_lvl[k][c] = s[c]; m_run[k][c] = 0; end
        end
      end
    end
    dlog.push_back(d_in);
  endtask

  task automatic compare_all();
    chk("d0_level", 32'(lvl0), 32'(m_lvl[0]));
    chk("d0_rise",  32'(rise0), 32'(m_lvl[0] & ~m_prev[0]));
    chk("d0_fall",  32'(fall0), 32'(~m_lvl[0] & m_prev[0]));
    chk("d0_edge",  32'(edg0), 32'(m_lvl[0] ^ m_prev[0]));
    chk("d0_cnt",   32'(cnt0), 32'({8'(m_cnt[0][1]), 8'(m_cnt[0][0])}));
    chk("d1_level", 32'(lvl1), 32'(m_lvl[1]));
    chk("d1_rise",  32'(rise1), 32'(m_lvl[1] & ~m_prev[1]));
    chk("d1_fall",  32'(fall1), 32'(~m_lvl[1] & m_prev[1]));
    chk("d1_edge",  32'(edg1), 32'(m_lvl[1] ^ m_prev[1]));
    chk("d1_cnt",   32'(cnt1), 32'({3'(m_cnt[1][1]), 3'(m_cnt[1][0])}));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lvl0"}, 32'(lvl0), 32'h3);
    chk({tag, "_edg0"}, 32'({rise0, fall0, edg0}), 32'h0);
    chk({tag, "_cnt0"}, 32'(cnt0), 32'h0);
    chk({tag, "_lvl1"}, 32'(lvl1), 32'h3);
    chk({tag, "_edg1"}, 32'({rise1, fall1, edg1}), 32'h0);
    chk({tag, "_cnt1"}, 32'(cnt1), 32'h0);
  endtask

  typedef struct {
    bit [1:0] d;
    bit [1:0] lvl;
    bit [1:0] fall;
    bit [7:0] c0;
  } vec_t;

  vec_t tbl[6];
  int   np, nx, nb;
  int   snap0, snap1;

  initial begin
    // Both instances flip at edge 4 (2+2 and 3+1), so one table covers both.
    tbl[0] = '{2'b10, 2'b11, 2'b00, 8'd0};
    tbl[1] = '{2'b10, 2'b11, 2'b00, 8'd0};
    tbl[2] = '{2'b10, 2'b11, 2'b00, 8'd0};
    tbl[3] = '{2'b10, 2'b10, 2'b01, 8'd0};
    tbl[4] = '{2'b10, 2'b10, 2'b00, 8'd1};
    tbl[5] = '{2'b10, 2'b10, 2'b00, 8'd1};

    n_rst = 1'b0; d_in = 2'b11; en = 1'b1; cnt_clr = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("rst_hold");
    tick(); tick();
    n_rst = 1'b1;

    // Idle: no pulses while input sits at the reset level.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_d0", 32'({lvl0, edg0, cnt0}), 32'({2'b11, 2'b00, 16'h0}));
      chk("idle_d1", 32'({lvl1, edg1, cnt1}), 32'({2'b11, 2'b00, 6'h0}));
    end

    // Latency table.
    for (int r = 0; r < 6; r++) begin
      d_in = tbl[r].d;
      tick();
      chk($sformatf("lat%0d_lvl0", r), 32'(lvl0), 32'(tbl[r].lvl));
      chk($sformatf("lat%0d_fall0", r), 32'(fall0), 32'(tbl[r].fall));
      chk($sformatf("lat%0d_edg0", r), 32'(edg0), 32'(tbl[r].fall));
      chk($sformatf("lat%0d_cnt0", r), 32'(cnt0[7:0]), 32'(tbl[r].c0));
      chk($sformatf("lat%0d_lvl1", r), 32'(lvl1), 32'(tbl[r].lvl));
      chk($sformatf("lat%0d_fall1", r), 32'(fall1), 32'(tbl[r].fall));
      chk($sformatf("lat%0d_cnt1", r), 32'(cnt1[2:0]), 32'(tbl[r].c0));
    end

    // Glitch: one low cycle on ch1 is rejected by the filtered instance.
    np = 0;
    d_in = 2'b00; tick(); np += fall0[1];
    d_in = 2'b10;
    for (int i = 0; i < 8; i++) begin tick(); np += fall0[1]; end
    chk("glitch1_pulses", 32'(np), 32'd0);
    chk("glitch1_lvl", 32'(lvl0), 32'h2);
    chk("glitch1_cnt", 32'(cnt0[15:8]), 32'd0);

    // Two low cycles are accepted.
    np = 0;
    d_in = 2'b00;
    for (int i = 0; i < 8; i++) begin tick(); np += fall0[1]; end
    chk("glitch2_pulses", 32'(np), 32'd1);
    chk("glitch2_lvl", 32'(lvl0), 32'h0);
    chk("glitch2_cnt", 32'(cnt0[15:8]), 32'd1);

    // Back high, then high-low-high-low style glitch train is rejected.
    d_in = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    chk("glitch3_pre", 32'(lvl0), 32'h2);
    np = 0;
    d_in = 2'b00; tick(); np += fall0[1];
    d_in = 2'b10; tick(); np += fall0[1];
    d_in = 2'b00; tick(); np += fall0[1];
    d_in = 2'b10;
    for (int i = 0; i < 8; i++) begin tick(); np += fall0[1]; end
    chk("glitch3_pulses", 32'(np), 32'd0);
    chk("glitch3_lvl", 32'(lvl0), 32'h2);

    // Simultaneous falls on both channels.
    d_in = 2'b11;
    for (int i = 0; i < 8; i++) tick();
    snap0 = m_cnt[0][0]; snap1 = m_cnt[0][1];
    np = 0; nx = 0;
    d_in = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fall0 == 2'b11) np++;
      if (fall0 == 2'b01 || fall0 == 2'b10) nx++;
    end
    chk("simul_both", 32'(np), 32'd1);
    chk("simul_split", 32'(nx), 32'd0);
    chk("simul_cnt", 32'(cnt0), 32'({8'(snap1 + 1), 8'(snap0 + 1)}));

    // Only ch1 toggles; ch0 stays static.
    np = 0; nx = 0;
    d_in = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick();
      nx += rise0[0] + fall0[0] + lvl0[0];
      np += rise0[1];
    end
    chk("indep_ch0", 32'(nx), 32'd0);
    chk("indep_ch1", 32'(np), 32'd1);

    // Saturation on the 3-bit instance.
    for (int i = 0; i < 9; i++) begin
      d_in[0] = ~d_in[0];
      for (int j = 0; j < 6; j++) tick();
    end
    chk("sat_cnt1", 32'(cnt1[2:0]), 32'd7);

    // Clear coincident with an edge wins, next edge counts 1.
    d_in = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    chk("clr_edge_d0", 32'(edg0[0]), 32'd1);
    chk("clr_edge_d1", 32'(edg1[0]), 32'd1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_cnt0", 32'(cnt0), 32'h0);
    chk("clr_cnt1", 32'(cnt1), 32'h0);
    d_in = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    chk("post_clr_cnt0", 32'(cnt0), 32'h0001);
    chk("post_clr_cnt1", 32'(cnt1), 32'h01);

    // Enable low: level frozen, no pulses.
    en = 1'b0;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      d_in[0] = ~d_in[0];
      tick();
      if (lvl0 != 2'b11 || lvl1 != 2'b11 || edg0 != 0 || edg1 != 0) nb++;
    end
    d_in = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (lvl0 != 2'b11 || edg0 != 0) nb++;
    end
    chk("en0_frozen", 32'(nb), 32'd0);
    en = 1'b1;
    np = 0;
    tick(); np += fall0[0];
    chk("en1_wait", 32'(lvl0), 32'h3);
    tick(); np += fall0[0];
    chk("en1_flip", 32'(lvl0), 32'h2);
    for (int i = 0; i < 6; i++) begin tick(); np += fall0[0]; end
    chk("en1_pulses", 32'(np), 32'd1);

    // Asynchronous reset while the filter is mid-count.
    d_in = 2'b11;
    tick(); tick(); tick();
    #3;
    n_rst = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("async_rst");
    compare_all();
    tick();
    n_rst = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) d_in[0] = ~d_in[0];
      if ($urandom_range(0, 3) == 0) d_in[1] = ~d_in[1];
      en      = ($urandom_range(0, 15) != 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised multi-channel successor to the single-line USB edge detector.
- Per channel: input synchroniser, glitch filter, rise/fall/any-edge pulses and a saturating edge counter.
- Sits between the USB pads (D+, D-, and other async lines) and the RX decode/timer logic.
- Replaces the single-channel block wherever filtering or edge typing is needed.

Parameters:
- NUM_CH, 2, number of independent input channels.
- SYNC_STAGES, 2, flops in each synchroniser chain (min 1).
- FILTER_LEN, 2, consecutive differing synchronised samples needed to accept a new level (min 1; 1 = no filtering).
- RESET_VAL, {NUM_CH{1'b1}}, per-channel idle/reset level (bit i for channel i).
- CNT_W, 8, width of each per-channel edge counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  async active-low reset
- d_in  in  NUM_CH  raw asynchronous inputs
- en  in  1  filter/edge enable
- cnt_clr  in  1  synchronous clear of all edge counters
- level  out  NUM_CH  filtered level
- rise  out  NUM_CH  one-cycle pulse on filtered 0->1
- fall  out  NUM_CH  one-cycle pulse on filtered 1->0
- d_edge  out  NUM_CH  rise | fall
- edge_cnt  out  NUM_CH*CNT_W  per-channel saturating edge count; channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk, rising edge.
- Reset state, per channel i:
  - All sync flops, level[i] and the delayed copy prev[i] = RESET_VAL[i].
  - Filter counter = 0; edge_cnt = 0.
  - rise/fall/d_edge = 0.
- Synchroniser: shift chain of SYNC_STAGES flops, always running (independent of en). s[i] is the last stage.
- Filter, per channel, each clock with en=1:
  - s == level: filter counter <= 0.
  - s != level and counter == FILTER_LEN-1: level <= s, counter <= 0.
  - s != level otherwise: counter <= counter + 1.
  - Counter width is clog2(FILTER_LEN) (min 1 bit).
- Glitch rejection: an input pulse shorter than FILTER_LEN synchronised samples never changes level. Any return to the current level restarts the count from 0.
- en=0:
  - level holds and filter counters are forced to 0.
  - prev tracks level, so no pulses are generated.
  - Re-enabling after en=0 never produces a spurious pulse.
- Edge pulses, combinational from registers:
  - rise = level & ~prev; fall = ~level & prev; d_edge = level ^ prev.
  - prev <= level every clock.
  - Each pulse is exactly one cycle per accepted transition.
- Latency: d_in changes and is stable before clk edge 1. level flips at edge SYNC_STAGES+FILTER_LEN, and the pulse is high for the cycle that follows. With defaults: flip at edge 4, pulse between edges 4 and 5.
- Edge counter, per channel:
  - cnt_clr=1: count <= 0. Clear has priority over a coincident edge, which is not counted.
  - Otherwise, on d_edge[i]=1: count increments, saturating at 2^CNT_W-1 (no wrap).
- Channels are fully independent. Simultaneous edges on several channels are each pulsed and counted.
- Reset mid-operation: every register returns to its reset state immediately. Outputs are valid reset values while n_rst=0.

Test Plan:
- Reset/idle (defaults NUM_CH=2, RESET_VAL=2'b11): hold n_rst=0, d_in=2'b11 -> level=2'b11, rise/fall/d_edge=0, edge_cnt=0. Release and hold d_in -> no pulses for 20 cycles.
- Latency: d_in[0] 1->0 before edge 1 -> level[0]=0 after edge 4. fall[0]=d_edge[0]=1 for exactly one cycle (edges 4-5). edge_cnt ch0 = 1. Repeat with SYNC_STAGES=3, FILTER_LEN=1 -> flip at edge 4.
- Glitch: d_in[1] low for 1 cycle (FILTER_LEN=2) -> level[1] unchanged, no pulse, count unchanged. Low for 2 cycles -> accepted and fall[1] pulses. Low 1 cycle, high 1, low 1 -> rejected.
- Simultaneous/independence: toggle d_in 2'b11->2'b00 in one cycle -> fall=2'b11 in the same cycle, both counts +1. Toggle only ch1 -> ch0 outputs static.
- Counter: CNT_W=3, apply 9 accepted edges -> count saturates at 7. Assert cnt_clr in the same cycle as an edge -> count=0. Next edge -> count=1.
- Enable / mid-op reset: en=0, toggle d_in[0] 10 cycles -> level frozen, no pulses. en=1 with input still different -> transition accepted after FILTER_LEN cycles with a single pulse. Assert n_rst while the filter counter is nonzero -> all outputs return to reset values asynchronously.
